instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction issue sequencer placed in front of the bus-based processor core. Buffers up to DEPTH 11-bit instructions from a host in a FIFO. Presents each instruction, zero-padded to the 16-bit bus width, to the core, then waits for the core's Done before issuing the next. A watchdog flags any instruction whose Done never arrives, so a hung control sequence cannot stall the host silently.

## Interface

Parameters:
- INSTR_WIDTH, 11, instruction field width.
- BUS_WIDTH, 16, core bus width; must be ≥ INSTR_WIDTH.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- TIMEOUT, 15, maximum WAIT cycles per instruction; ≥ 1.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, synchronous active-high reset.
- in_instr, input, INSTR_WIDTH, instruction from host.
- in_valid, input, 1, host offers in_instr this cycle.
- in_ready, output, 1, FIFO can accept; combinational, equals (level < DEPTH).
- cpu_instr, output, BUS_WIDTH, registered {zeros, head instruction} driven to the core.
- cpu_start, output, 1, registered one-cycle pulse marking a new instruction.
- cpu_done, input, 1, core completion strobe.
- err_clear, input, 1, acknowledge and clear a timeout.
- busy, output, 1, high when state ≠ IDLE or level > 0.
- error, output, 1, high while in ERR.
- level, output, clog2(DEPTH)+1, FIFO occupancy.
- issued_count, output, 8, instructions completed with Done; wraps 255→0.

## Operation

- Push: in_valid && in_ready at an edge writes in_instr at the tail and increments level. A push while full is dropped; in_ready is already low.
- The FIFO is popped only by the FSM, never by the host.
- FSM states: IDLE, ISSUE, WAIT, ERR.
  - IDLE → ISSUE when level > 0.
  - ISSUE → WAIT unconditionally. cpu_start = 1 during ISSUE only.
  - WAIT → IDLE on cpu_done. This pops the head and increments issued_count.
  - WAIT → ERR when the watchdog expires without cpu_done. This pops (discards) the head, and issued_count is unchanged.
  - ERR → IDLE on err_clear. err_clear in any other state is ignored.
- cpu_done is sampled only in WAIT. A Done strobe in IDLE, ISSUE or ERR is ignored.
- cpu_instr holds {(BUS_WIDTH-INSTR_WIDTH)'b0, head} throughout ISSUE and WAIT, and is 0 in IDLE and ERR.
- Watchdog: the counter clears on entry to WAIT and increments each WAIT cycle without Done. Expiry occurs in the WAIT cycle where counter == TIMEOUT-1 and cpu_done = 0. If cpu_done = 1 in that same cycle, Done wins.
- Pop and push on the same edge are both honoured: level is unchanged, and the pointers advance independently, wrapping modulo DEPTH.
- In ERR the FIFO still accepts pushes.

## Timing

- Reset priority is over all inputs. On reset:
  - state = IDLE; FIFO emptied (pointers and level = 0).
  - cpu_instr = 0, cpu_start = 0, error = 0, issued_count = 0.
  - The watchdog counter clears.
  - busy = 0 and in_ready = 1 from the cycle after the reset edge.
- Reset mid-operation discards any in-flight and buffered instructions with no Done accounting.
- Issue latency from a push accepted at edge k into an empty, idle sequencer:
  - ISSUE is entered at edge k+1, so cpu_start is high for exactly the cycle after edge k+1.
  - WAIT is entered at edge k+2.
- Back-to-back issue: Done at edge d means IDLE after d. The next ISSUE is entered at d+1, a one-cycle bubble.
- Maximum WAIT dwell is TIMEOUT cycles. ERR is entered at the edge ending the TIMEOUT-th WAIT cycle.
- error rises the cycle ERR is entered and falls the cycle after the err_clear edge.

## Test plan

- Reset then a single push of 11'h5A3 → cpu_start pulses once with cpu_instr = 16'h05A3. Done after 3 WAIT cycles → cpu_instr returns to 0, issued_count = 1, level = 0, busy = 0.
- Push 5 instructions back-to-back with DEPTH = 4 and cpu_done held low → in_ready falls after the 4th push and the 5th is dropped. With Done returned, the next three instructions issue in order with exactly one idle cycle between cpu_start pulses.
- No Done with TIMEOUT = 15 → error rises after 15 WAIT cycles, the head is discarded and issued_count is unchanged. err_clear → IDLE, and the next queued instruction issues normally.
- cpu_done on the 15th WAIT cycle → no error, and issued_count increments.
- Stray cpu_done in IDLE and in the ISSUE cycle → ignored; state and counters unchanged.
- Reset asserted during WAIT with 3 entries queued → next cycle level = 0, cpu_instr = 0, state IDLE. 256 completions then wrap issued_count to 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction issue sequencer: FIFO-buffered host instructions handed one at a
// time to the core, with a per-instruction Done watchdog.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 11,
    parameter int BUS_WIDTH   = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INSTR_WIDTH-1:0]       in_instr,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [BUS_WIDTH-1:0]         cpu_instr,
    output logic                         cpu_start,
    input  logic                         cpu_done,
    input  logic                         err_clear,
    output logic                         busy,
    output logic                         error,
    output logic [$clog2(DEPTH):0]       level,
    output logic [7:0]                   issued_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [WW-1:0]          wdog;

    logic                   push;
    logic                   pop;
    logic                   wd_expire;
    logic                   done_inc;
    logic                   start_d;
    logic [BUS_WIDTH-1:0]   instr_d;

    assign in_ready  = (level < LW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign wd_expire = (state == WAIT) && !cpu_done
                       && (wdog == WW'(TIMEOUT - 1));
    assign busy      = (state != IDLE) || (level != '0);
    assign error     = (state == ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (level != '0) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (cpu_done) begin
                    state_next = IDLE;
                end else if (wd_expire) begin
                    state_next = ERR;
                end
            end
            ERR:   if (err_clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The head cannot move while heading into ISSUE/WAIT, so it is safe to
    // latch it into the bus register on the same edge.
    always_comb begin
        pop      = (state == WAIT) && (cpu_done || wd_expire);
        done_inc = (state == WAIT) && cpu_done;
        start_d  = (state_next == ISSUE);
        instr_d  = '0;
        if (state_next == ISSUE || state_next == WAIT) begin
            instr_d = BUS_WIDTH'(mem[rd_ptr]);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            wdog         <= '0;
            issued_count <= '0;
            cpu_start    <= 1'b0;
            cpu_instr    <= '0;
        end else begin
            cpu_start <= start_d;
            cpu_instr <= instr_d;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            if (state == ISSUE) begin
                wdog <= '0;
            end else if (state == WAIT && !cpu_done) begin
                wdog <= wdog + WW'(1);
            end
            if (done_inc) begin
                issued_count <= issued_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: issue timing, FIFO full, watchdog,
// stray Done, reset mid-operation and issued_count wrap.
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic [10:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] cpu_instr;
    logic        cpu_start;
    logic        cpu_done;
    logic        err_clear;
    logic        busy;
    logic        error;
    logic [2:0]  level;
    logic [7:0]  issued_count;

    int total;
    int bad;

    logic [10:0] vals [5];

    instr_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cpu_instr    (cpu_instr),
        .cpu_start    (cpu_start),
        .cpu_done     (cpu_done),
        .err_clear    (err_clear),
        .busy         (busy),
        .error        (error),
        .level        (level),
        .issued_count (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_instr  = '0;
        in_valid  = 1'b0;
        cpu_done  = 1'b0;
        err_clear = 1'b0;
        vals[0] = 11'h101;
        vals[1] = 11'h202;
        vals[2] = 11'h303;
        vals[3] = 11'h404;
        vals[4] = 11'h7FF;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_instr", cpu_instr, 0);
        chk("rst_start", cpu_start, 0);
        chk("rst_error", error, 0);
        chk("rst_count", issued_count, 0);

        // single push and issue latency
        in_valid = 1'b1;
        in_instr = 11'h5A3;
        tick();
        in_valid = 1'b0;
        chk("p1_level", level, 1);
        chk("p1_start", cpu_start, 0);
        chk("p1_busy", busy, 1);
        tick();
        chk("p1_issue_start", cpu_start, 1);
        chk("p1_issue_instr", cpu_instr, 16'h05A3);
        tick();
        chk("p1_wait_start", cpu_start, 0);
        chk("p1_wait_instr", cpu_instr, 16'h05A3);
        tick();
        tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("p1_done_instr", cpu_instr, 0);
        chk("p1_done_count", issued_count, 1);
        chk("p1_done_level", level, 0);
        chk("p1_done_busy", busy, 0);

        // stray done in IDLE
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("stray_idle_count", issued_count, 1);
        chk("stray_idle_busy", busy, 0);
        // stray done in ISSUE
        in_valid = 1'b1;
        in_instr = 11'h0AB;
        tick();
        in_valid = 1'b0;
        tick();
        chk("stray_issue_start", cpu_start, 1);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("stray_issue_count", issued_count, 1);
        chk("stray_issue_instr", cpu_instr, 16'h00AB);
        chk("stray_issue_level", level, 1);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("stray_after_count", issued_count, 2);

        // fill past full
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1;
            in_instr = vals[j];
            tick();
            if (j == 3) begin
                chk("full_ready", in_ready, 0);
                chk("full_level", level, 4);
            end
        end
        in_valid = 1'b0;
        chk("drop_level", level, 4);
        chk("fill_head", cpu_instr, {5'b0, vals[0]});
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("fill_count", issued_count, 3);
        chk("fill_level", level, 3);
        for (int j = 1; j < 4; j++) begin
            tick();
            chk("seq_start", cpu_start, 1);
            chk("seq_instr", cpu_instr, {5'b0, vals[j]});
            tick();
            chk("seq_wait_start", cpu_start, 0);
            cpu_done = 1'b1;
            tick();
            cpu_done = 1'b0;
            chk("seq_bubble_start", cpu_start, 0);
        end
        chk("seq_count", issued_count, 6);
        chk("seq_level", level, 0);
        chk("seq_busy", busy, 0);

        // watchdog expiry
        in_valid = 1'b1;
        in_instr = 11'h111;
        tick();
        in_instr = 11'h222;
        tick();
        in_valid = 1'b0;
        tick();
        chk("wd_instr", cpu_instr, 16'h0111);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("wd_noerr", error, 0);
        end
        tick();
        chk("wd_error", error, 1);
        chk("wd_count", issued_count, 6);
        chk("wd_level", level, 1);
        chk("wd_instr0", cpu_instr, 0);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("err_stray_done", error, 1);
        chk("err_stray_count", issued_count, 6);
        in_valid = 1'b1;
        in_instr = 11'h333;
        tick();
        in_valid = 1'b0;
        chk("err_push_level", level, 2);
        chk("err_still", error, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_error", error, 0);
        tick();
        chk("clr_issue_start", cpu_start, 1);
        chk("clr_issue_instr", cpu_instr, 16'h0222);
        tick();
        // Done on the last allowed WAIT cycle
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("edge_error", error, 0);
        chk("edge_count", issued_count, 7);
        chk("edge_level", level, 1);

        // reset during WAIT with 3 queued
        tick();
        chk("g_instr", cpu_instr, 16'h0333);
        tick();
        in_valid = 1'b1;
        in_instr = 11'h444;
        tick();
        in_instr = 11'h555;
        tick();
        in_valid = 1'b0;
        chk("q3_level", level, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_level", level, 0);
        chk("mrst_instr", cpu_instr, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_count", issued_count, 0);
        chk("mrst_ready", in_ready, 1);
        tick();
        chk("mrst_idle_start", cpu_start, 0);

        // count wrap
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_instr = 11'(i);
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            cpu_done = 1'b1;
            tick();
            cpu_done = 1'b0;
            if (i == 254) begin
                chk("wrap_255", issued_count, 255);
            end
        end
        chk("wrap_0", issued_count, 0);
        chk("wrap_level", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
